// File: rtl/bin_to_bcd_8.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_8
//   Sequential binary-to-BCD converter (double dabble, one bit per clock).
//   Accepts one unsigned operand at a time over a valid/ready handshake and
//   presents the unpacked BCD digit array, saturated to all 9s with out_ovf
//   set when the operand does not fit in DIGITS decimal digits.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream presents in_bin
//   in_ready   converter is idle and can take an operand
//   in_bin     unsigned binary operand (BIN_W bits)
//   out_valid  out_bcd / out_ovf hold a finished result
//   out_ready  downstream takes the result
//   out_bcd    BCD digits, index 0 = least significant
//   out_ovf    operand exceeded 10^DIGITS-1, out_bcd is saturated
// ---------------------------------------------------------------------------
module bin_to_bcd_8 #(
  parameter int DIGITS = 8,
  parameter int BIN_W  = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_bcd [DIGITS-1:0],
  output logic             out_ovf
);

  localparam int DW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Largest value representable in DIGITS decimal digits.
  function automatic logic [63:0] max_dec(input int n);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < n; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_dec(DIGITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [DW-1:0]    dig_q, dig_d;
  logic [DW-1:0]    dig_adj;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_ovf_q;
  logic [3:0]       out_bcd_q [DIGITS-1:0];
  logic             in_ovf;

  assign in_ovf = ({{(64-BIN_W){1'b0}}, in_bin} > MAX_VAL);

  // One double-dabble step: add 3 to every digit >= 5, then shift the
  // {digits, binary} pair left with the binary MSB entering digit 0.
  // NOTE: every variable assigned in always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    dig_adj = dig_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (dig_q[4*d +: 4] >= 4'd5) dig_adj[4*d +: 4] = dig_q[4*d +: 4] + 4'd3;
    end
    dig_d = {dig_adj[DW-2:0], bin_q[BIN_W-1]};
    bin_d = {bin_q[BIN_W-2:0], 1'b0};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the output digit array is reset too, because downstream may
      // observe out_bcd right after reset and must see zeros, not X.
      state_q     <= IDLE;
      bin_q       <= '0;
      dig_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      for (int d = 0; d < DIGITS; d++) out_bcd_q[d] <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bin_q      <= in_bin;
            dig_q      <= '0;
            ovf_q      <= in_ovf;
            cnt_q      <= CNT_W'(BIN_W);
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          dig_q <= dig_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q - CNT_W'(1);
          // Last shift: publish the finished value in one step so that no
          // partial result ever reaches out_bcd.
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_ovf_q   <= ovf_q;
            for (int d = 0; d < DIGITS; d++) begin
              out_bcd_q[d] <= ovf_q ? 4'd9 : dig_d[4*d +: 4];
            end
          end
        end
        DONE: begin
          // A same-cycle in_valid is ignored here; it is taken next cycle.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ovf   = out_ovf_q;
  assign out_bcd   = out_bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_8.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_8
//   Self-checking bench for bin_to_bcd_8: directed cases plus randomized
//   operands with random output stalls, checked against a decimal model.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_8;

  localparam int DIGITS = 8;
  localparam int BIN_W  = 27;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [BIN_W-1:0] in_bin;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_bcd [DIGITS-1:0];
  logic             out_ovf;

  int n_cmp = 0;
  int n_err = 0;

  bin_to_bcd_8 #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish (got timeout, want completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Digits packed as a hex-looking word, digit 7 in the top nibble.
  function automatic logic [31:0] bcd_word();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = out_bcd[i];
    return r;
  endfunction

  // Decimal reference: extract digits by division, saturate above 99999999.
  task automatic model(input longint v, output logic [31:0] b, output logic o);
    longint p;
    b = '0;
    o = 1'b0;
    if (v > 64'd99999999) begin
      b = 32'h9999_9999;
      o = 1'b1;
    end else begin
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
        b[4*i +: 4] = 4'((v / p) % 10);
        p = p * 10;
      end
    end
  endtask

  // Full transaction: offer v, wait for acceptance, measure latency, check
  // the result, hold it for 'stall' cycles, then hand it off. If next_valid
  // is set, the next operand is presented in the same cycle as the output
  // handshake and must not be taken until the following IDLE cycle.
  task automatic run_op(input logic [BIN_W-1:0] v, input int stall,
                        input bit next_valid, input logic [BIN_W-1:0] next_v);
    logic [31:0] exp_bcd;
    logic        exp_ovf;
    int          n;
    model(longint'(v), exp_bcd, exp_ovf);
    in_bin   = v;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_in_ready", {63'd0, in_ready}, 64'd0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("latency", 64'(n), 64'(BIN_W));
    check("bcd", {32'd0, bcd_word()}, {32'd0, exp_bcd});
    check("ovf", {63'd0, out_ovf}, {63'd0, exp_ovf});
    check("done_in_ready", {63'd0, in_ready}, 64'd0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      check("stall_bcd", {32'd0, bcd_word()}, {32'd0, exp_bcd});
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    if (next_valid) begin
      in_bin   = next_v;
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", {63'd0, out_valid}, 64'd0);
    check("post_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_bcd_kept", {32'd0, bcd_word()}, {32'd0, exp_bcd});
  endtask

  initial begin
    logic [BIN_W-1:0] v;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bin    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_ovf", {63'd0, out_ovf}, 64'd0);
    check("rst_bcd", {32'd0, bcd_word()}, 64'd0);

    // Directed cases.
    run_op(27'd12345678, 0, 1'b0, '0);
    run_op(27'd0, 1, 1'b1, 27'd99999999);
    run_op(27'd99999999, 0, 1'b0, '0);
    run_op(27'd100000000, 2, 1'b0, '0);
    run_op(27'h7FF_FFFF, 0, 1'b0, '0);
    run_op(27'd905, 10, 1'b0, '0);

    // Reset in the middle of a conversion of 42 (at shift edge 10).
    in_bin   = 27'd42;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_bcd", {32'd0, bcd_word()}, 64'd0);
    check("abort_ovf", {63'd0, out_ovf}, 64'd0);
    run_op(27'd42, 0, 1'b0, '0);

    // Randomized operands, mixing full-range and small values.
    for (int k = 0; k < 1000; k++) begin
      case ($urandom_range(0, 3))
        0:       v = BIN_W'($urandom_range(0, 999));
        1:       v = BIN_W'($urandom_range(99_999_990, 100_000_010));
        default: v = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
      endcase
      run_op(v, int'($urandom_range(0, 3)), 1'b0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
